// File: rtl/workout_timer_pkg.sv
// Shared types and constants for the workout timer: FSM states, the BCD digit type and digit limits.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

  // Presets outside a digit's range are pinned to the digit's maximum.
  function automatic bcd_t bcd_clamp(input bcd_t val, input bcd_t max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/workout_timer_if.sv
// Control/display bundle of the workout timer; lap signals exist only when TIMER_LAP_EN is defined.
interface workout_timer_if #(
  parameter int MIN_DIGITS = 2
);
  logic                    run;
  logic                    dir;
  logic                    load;
  logic [4*MIN_DIGITS-1:0] load_min;
  logic [7:0]              load_sec;
  logic [4*MIN_DIGITS-1:0] minutes;
  logic [7:0]              seconds;
  logic                    done;
  logic                    running;
`ifdef TIMER_LAP_EN
  logic                    lap;
  logic [4*MIN_DIGITS-1:0] lap_min;
  logic [7:0]              lap_sec;
  logic                    lap_valid;
`endif

  modport master (
    output run, dir, load, load_min, load_sec,
`ifdef TIMER_LAP_EN
    output lap,
    input  lap_min, lap_sec, lap_valid,
`endif
    input  minutes, seconds, done, running
  );

  modport slave (
    input  run, dir, load, load_min, load_sec,
`ifdef TIMER_LAP_EN
    input  lap,
    output lap_min, lap_sec, lap_valid,
`endif
    output minutes, seconds, done, running
  );

endinterface

// File: rtl/workout_timer_bcd_digit.sv
// One BCD counter digit wrapping at MAX, with ripple carry/borrow and a clamped synchronous preset.
module bcd_digit
  import timer_pkg::*;
#(
  parameter bcd_t MAX = DIGIT_MAX
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  bcd_t load_val_i,
  input  logic down_i,
  input  logic cin_i,
  output logic cout_o,
  output bcd_t q_o,
  output bcd_t d_o
);

  bcd_t digit_q, digit_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    digit_d = digit_q;
    if (cin_i) begin
      if (down_i) begin
        digit_d = (digit_q == 4'd0) ? MAX : digit_q - 4'd1;
      end else begin
        digit_d = (digit_q >= MAX) ? 4'd0 : digit_q + 4'd1;
      end
    end
  end

  assign cout_o = cin_i && (down_i ? (digit_q == 4'd0) : (digit_q >= MAX));

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digit_q <= 4'd0;
    end else if (load_i) begin
      digit_q <= bcd_clamp(load_val_i, MAX);
    end else begin
      digit_q <= digit_d;
    end
  end

  assign q_o = digit_q;
  assign d_o = digit_d;

endmodule

// File: rtl/workout_timer.sv
// BCD mm:ss workout timer counting up or down with pause, preset and terminal stop.
// Optional lap capture is enabled by defining TIMER_LAP_EN.
module workout_timer
  import timer_pkg::*;
#(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 1
) (
  input  logic                    slow_clock,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    dir,
  input  logic                    load,
  input  logic [4*MIN_DIGITS-1:0] load_min,
  input  logic [7:0]              load_sec,
  output logic [4*MIN_DIGITS-1:0] minutes,
  output logic [7:0]              seconds,
  output logic                    done,
  output logic                    running
`ifdef TIMER_LAP_EN
  ,
  input  logic                    lap,
  output logic [4*MIN_DIGITS-1:0] lap_min,
  output logic [7:0]              lap_sec,
  output logic                    lap_valid
`endif
);

  localparam int NDIG = MIN_DIGITS + 2;
  localparam int W    = 4 * NDIG;
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0]  MAX_VAL  = {{MIN_DIGITS{4'h9}}, 8'h59};
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          done_q, running_q;

  logic [W-1:0]  load_val;
  logic [W-1:0]  cur_val;
  logic [W-1:0]  nxt_val;
  logic [NDIG:0] carry;
  logic          tick, at_term, nxt_term;
  logic          unused_wrap;

  assign load_val = {load_min, load_sec};

  assign tick     = (state_q == RUN) && (pre_q == PRE_LAST);
  assign at_term  = dir ? (cur_val == '0) : (cur_val == MAX_VAL);
  assign nxt_term = dir ? (nxt_val == '0) : (nxt_val == MAX_VAL);

  // A tick never advances a value that is already terminal, so the count cannot wrap.
  assign carry[0]    = tick && !at_term;
  assign unused_wrap = carry[NDIG];

  // Digit 0 = seconds units, digit 1 = seconds tens, digits 2.. = minutes, least significant first.
  for (genvar i = 0; i < NDIG; i++) begin : g_digit
    localparam bcd_t DMAX = (i == 1) ? SEC_TENS_MAX : DIGIT_MAX;
    bcd_digit #(
      .MAX(DMAX)
    ) u_digit (
      .clk_i     (slow_clock),
      .rst_i     (reset),
      .load_i    (load),
      .load_val_i(load_val[4*i +: 4]),
      .down_i    (dir),
      .cin_i     (carry[i]),
      .cout_o    (carry[i+1]),
      .q_o       (cur_val[4*i +: 4]),
      .d_o       (nxt_val[4*i +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    if (load) begin
      state_d = IDLE;
      pre_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            state_d = at_term ? DONE : RUN;
            pre_d   = '0;
          end
        end
        RUN: begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (tick && (at_term || nxt_term)) begin
            state_d = DONE;
          end else if (!run) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (run) begin
            state_d = RUN;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      done_q    <= (state_d == DONE);
      running_q <= (state_d == RUN);
    end
  end

  assign minutes = cur_val[W-1:8];
  assign seconds = cur_val[7:0];
  assign done    = done_q;
  assign running = running_q;

`ifdef TIMER_LAP_EN
  logic [W-1:0] lap_q;
  logic         lap_valid_q;

  // Lap samples the registered display, i.e. the value before any tick on the same edge.
  always_ff @(posedge slow_clock) begin
    if (reset || load) begin
      lap_q       <= '0;
      lap_valid_q <= 1'b0;
    end else if (lap) begin
      lap_q       <= cur_val;
      lap_valid_q <= 1'b1;
    end
  end

  assign lap_min   = lap_q[W-1:8];
  assign lap_sec   = lap_q[7:0];
  assign lap_valid = lap_valid_q;
`endif

endmodule

// File: tb/tb_workout_timer.sv
// Directed bench for workout_timer: vector table on a TICK_DIV=1 instance plus prescaler sequences.
module tb_workout_timer;

  logic slow_clock;
  logic reset;

  workout_timer_if #(.MIN_DIGITS(2)) bus ();

  logic [7:0] d3_min, d3_sec, d4_min, d4_sec;
  logic       d3_done, d3_running, d4_done, d4_running;
`ifdef TIMER_LAP_EN
  logic [7:0] d3_lmin, d3_lsec, d4_lmin, d4_lsec;
  logic       d3_lval, d4_lval;
`endif

  workout_timer #(.MIN_DIGITS(2), .TICK_DIV(1)) u_dut1 (
    .slow_clock(slow_clock), .reset(reset),
    .run(bus.run), .dir(bus.dir), .load(bus.load),
    .load_min(bus.load_min), .load_sec(bus.load_sec),
    .minutes(bus.minutes), .seconds(bus.seconds),
    .done(bus.done), .running(bus.running)
`ifdef TIMER_LAP_EN
    , .lap(bus.lap), .lap_min(bus.lap_min), .lap_sec(bus.lap_sec), .lap_valid(bus.lap_valid)
`endif
  );

  workout_timer #(.MIN_DIGITS(2), .TICK_DIV(3)) u_dut3 (
    .slow_clock(slow_clock), .reset(reset),
    .run(bus.run), .dir(bus.dir), .load(bus.load),
    .load_min(bus.load_min), .load_sec(bus.load_sec),
    .minutes(d3_min), .seconds(d3_sec),
    .done(d3_done), .running(d3_running)
`ifdef TIMER_LAP_EN
    , .lap(bus.lap), .lap_min(d3_lmin), .lap_sec(d3_lsec), .lap_valid(d3_lval)
`endif
  );

  workout_timer #(.MIN_DIGITS(2), .TICK_DIV(4)) u_dut4 (
    .slow_clock(slow_clock), .reset(reset),
    .run(bus.run), .dir(bus.dir), .load(bus.load),
    .load_min(bus.load_min), .load_sec(bus.load_sec),
    .minutes(d4_min), .seconds(d4_sec),
    .done(d4_done), .running(d4_running)
`ifdef TIMER_LAP_EN
    , .lap(bus.lap), .lap_min(d4_lmin), .lap_sec(d4_lsec), .lap_valid(d4_lval)
`endif
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  typedef struct {
    logic       run;
    logic       dir;
    logic       load;
    logic [7:0] lmin;
    logic [7:0] lsec;
    logic [7:0] emin;
    logic [7:0] esec;
    logic       edone;
    logic       erun;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge slow_clock);
    @(negedge slow_clock);
  endtask

  task automatic drive(input logic r, input logic d, input logic l,
                       input logic [7:0] lm, input logic [7:0] ls);
    bus.run      = r;
    bus.dir      = d;
    bus.load     = l;
    bus.load_min = lm;
    bus.load_sec = ls;
  endtask

  task automatic chk1(input string name, input logic [7:0] m, input logic [7:0] s,
                      input logic dn, input logic rn);
    check({name, " time"}, {bus.minutes, bus.seconds}, {m, s});
    check({name, " done"}, bus.done, dn);
    check({name, " running"}, bus.running, rn);
  endtask

  function automatic vec_t mk(input logic r, input logic d, input logic l,
                              input logic [7:0] lm, input logic [7:0] ls,
                              input logic [7:0] em, input logic [7:0] es,
                              input logic ed, input logic er);
    vec_t v;
    v.run = r; v.dir = d; v.load = l; v.lmin = lm; v.lsec = ls;
    v.emin = em; v.esec = es; v.edone = ed; v.erun = er;
    return v;
  endfunction

  initial begin
    // run dir load lmin  lsec  -> min   sec   done running  (TICK_DIV=1)
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h58, 8'h00, 8'h58, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h58, 0, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h59, 0, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h01, 8'h00, 0, 1));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h59, 0, 1));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h58, 0, 1));
    vecs.push_back(mk(1, 1, 1, 8'h00, 8'h02, 8'h00, 8'h02, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h02, 0, 1));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 0, 1));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'hA3, 8'h7C, 8'h93, 8'h59, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h93, 8'h59, 0, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h94, 8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h99, 8'h59, 8'h99, 8'h59, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h99, 8'h59, 1, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h09, 8'h09, 8'h09, 8'h09, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h09, 8'h09, 0, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h09, 8'h10, 0, 1));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h09, 8'h09, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h10, 8'h00, 8'h10, 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h10, 8'h00, 0, 1));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h09, 8'h59, 0, 1));

    drive(0, 0, 0, 8'h00, 8'h00);
`ifdef TIMER_LAP_EN
    bus.lap = 1'b0;
`endif
    reset = 1'b1;
    @(negedge slow_clock);
    step();
    step();
    reset = 1'b0;
    chk1("reset", 8'h00, 8'h00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].run, vecs[i].dir, vecs[i].load, vecs[i].lmin, vecs[i].lsec);
      step();
      chk1($sformatf("vec%0d", i), vecs[i].emin, vecs[i].esec, vecs[i].edone, vecs[i].erun);
    end

    // Count down to 00:00 and hold there.
    drive(0, 1, 1, 8'h00, 8'h01);
    step();
    drive(1, 1, 0, 8'h00, 8'h00);
    step();
    chk1("down start", 8'h00, 8'h01, 0, 1);
    step();
    chk1("down terminal", 8'h00, 8'h00, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk1($sformatf("down hold%0d", i), 8'h00, 8'h00, 1, 0);
    end

    // Load on a tick edge wins, then reset mid-run.
    drive(0, 0, 1, 8'h00, 8'h10);
    step();
    drive(1, 0, 0, 8'h00, 8'h00);
    step();
    step();
    chk1("pre load tick", 8'h00, 8'h11, 0, 1);
    drive(1, 0, 1, 8'h12, 8'h3F);
    step();
    chk1("load on tick", 8'h12, 8'h39, 0, 0);
    drive(1, 0, 0, 8'h00, 8'h00);
    step();
    chk1("restart", 8'h12, 8'h39, 0, 1);
    step();
    chk1("after restart tick", 8'h12, 8'h40, 0, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk1("reset mid run", 8'h00, 8'h00, 0, 0);

    // TICK_DIV=3: stop at 99:59 without wrapping, then reset out of DONE.
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 0, 1, 8'h99, 8'h58);
    step();
    drive(1, 0, 0, 8'h00, 8'h00);
    step();
    check("td3 start running", d3_running, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("td3 wait%0d time", i), {d3_min, d3_sec}, 16'h9958);
    end
    step();
    check("td3 tick time", {d3_min, d3_sec}, 16'h9959);
    check("td3 tick done", d3_done, 1'b1);
    check("td3 tick running", d3_running, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("td3 hold%0d time", i), {d3_min, d3_sec}, 16'h9959);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("td3 reset in done time", {d3_min, d3_sec}, 16'h0000);
    check("td3 reset in done done", d3_done, 1'b0);

    // TICK_DIV=4: prescaler holds through pause; first tick two edges after resume.
    drive(0, 0, 1, 8'h00, 8'h00);
    step();
    drive(1, 0, 0, 8'h00, 8'h00);
    step();
    step();
    drive(0, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) step();
    check("td4 paused running", d4_running, 1'b0);
    check("td4 paused time", {d4_min, d4_sec}, 16'h0000);
    drive(1, 0, 0, 8'h00, 8'h00);
    step();
    check("td4 resume running", d4_running, 1'b1);
    check("td4 resume time", {d4_min, d4_sec}, 16'h0000);
    step();
    check("td4 resume+1 time", {d4_min, d4_sec}, 16'h0000);
    step();
    check("td4 resume+2 time", {d4_min, d4_sec}, 16'h0001);
    for (int i = 0; i < 4; i++) step();
    check("td4 next period time", {d4_min, d4_sec}, 16'h0002);

`ifdef TIMER_LAP_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 0, 1, 8'h05, 8'h16);
    step();
    drive(1, 0, 0, 8'h00, 8'h00);
    step();
    step();
    chk1("lap pre", 8'h05, 8'h17, 0, 1);
    bus.lap = 1'b1;
    step();
    bus.lap = 1'b0;
    check("lap min", bus.lap_min, 8'h05);
    check("lap sec", bus.lap_sec, 8'h17);
    check("lap valid", bus.lap_valid, 1'b1);
    check("lap time", {bus.minutes, bus.seconds}, 16'h0518);
    drive(0, 0, 1, 8'h00, 8'h00);
    step();
    check("lap cleared valid", bus.lap_valid, 1'b0);
    check("lap cleared value", {bus.lap_min, bus.lap_sec}, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
